// File: rtl/htu_ref_cnt.sv
// Per-(set,way) saturating reference counters with a 1-cycle write-first read port and a busy-entry count.
// Optional macro HTU_REF_CNT_CHECK_EN enables the sticky over/underflow flag ref_cnt_err.
module htu_ref_cnt #(
   parameter int SetNum   = 64,
   parameter int WayNum   = 4,
   parameter int CntWidth = 3,
   localparam int SW = $clog2(SetNum),
   localparam int WW = $clog2(WayNum),
   localparam int BW = SW + WW + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SW-1:0]                ref_cnt_set,
   output logic [CntWidth*WayNum-1:0]   ref_cnt_rsp,
   input  logic                         ref_cnt_access_valid,
   input  logic [SW-1:0]                ref_cnt_access_set,
   input  logic [WW-1:0]                ref_cnt_access_way,
   input  logic                         ref_cnt_release_valid,
   input  logic [SW-1:0]                ref_cnt_release_set,
   input  logic [WW-1:0]                ref_cnt_release_way,
   output logic [BW-1:0]                ref_cnt_busy_cnt,
   output logic                         ref_cnt_err
);

   localparam logic [CntWidth-1:0] MAX = '1;
   localparam logic [CntWidth-1:0] ONE = CntWidth'(1);

   logic [CntWidth-1:0] cnt [SetNum][WayNum];

   logic                       acc_ok, rel_ok, rd_ok, same_entry;
   logic                       do_acc, do_rel, busy_inc, busy_dec;
   logic [SW-1:0]              acc_set, rel_set, rd_set;
   logic [WW-1:0]              acc_way, rel_way;
   logic [CntWidth-1:0]        acc_cur, acc_new, rel_cur, rel_new;
   logic [CntWidth*WayNum-1:0] rsp_next;

   // Out-of-range indices are dropped and the array index is forced to 0 so reads stay in bounds.
   always_comb begin
      acc_ok = ref_cnt_access_valid
               && ({1'b0, ref_cnt_access_set} < (SW+1)'(SetNum))
               && ({1'b0, ref_cnt_access_way} < (WW+1)'(WayNum));
      rel_ok = ref_cnt_release_valid
               && ({1'b0, ref_cnt_release_set} < (SW+1)'(SetNum))
               && ({1'b0, ref_cnt_release_way} < (WW+1)'(WayNum));
      rd_ok  = {1'b0, ref_cnt_set} < (SW+1)'(SetNum);

      acc_set = acc_ok ? ref_cnt_access_set  : '0;
      acc_way = acc_ok ? ref_cnt_access_way  : '0;
      rel_set = rel_ok ? ref_cnt_release_set : '0;
      rel_way = rel_ok ? ref_cnt_release_way : '0;
      rd_set  = rd_ok  ? ref_cnt_set         : '0;

      // An access and a release on the same entry cancel, even at the saturation limits.
      same_entry = acc_ok && rel_ok && (acc_set == rel_set) && (acc_way == rel_way);
      do_acc     = acc_ok && !same_entry;
      do_rel     = rel_ok && !same_entry;

      acc_cur = cnt[acc_set][acc_way];
      rel_cur = cnt[rel_set][rel_way];
      acc_new = (acc_cur == MAX) ? MAX : acc_cur + ONE;
      rel_new = (rel_cur == '0)  ? '0  : rel_cur - ONE;

      busy_inc = do_acc && (acc_cur == '0);
      busy_dec = do_rel && (rel_cur == ONE);

      rsp_next = '0;
      if (rd_ok) begin
         for (int w = 0; w < WayNum; w++) begin
            rsp_next[w*CntWidth +: CntWidth] = cnt[rd_set][w];
            if (do_acc && (acc_set == rd_set) && (acc_way == WW'(w)))
               rsp_next[w*CntWidth +: CntWidth] = acc_new;
            if (do_rel && (rel_set == rd_set) && (rel_way == WW'(w)))
               rsp_next[w*CntWidth +: CntWidth] = rel_new;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SetNum; s++)
            for (int w = 0; w < WayNum; w++)
               cnt[s][w] <= '0;
         ref_cnt_rsp      <= '0;
         ref_cnt_busy_cnt <= '0;
      end else begin
         if (do_acc)
            cnt[acc_set][acc_way] <= acc_new;
         if (do_rel)
            cnt[rel_set][rel_way] <= rel_new;
         ref_cnt_rsp      <= rsp_next;
         ref_cnt_busy_cnt <= ref_cnt_busy_cnt + BW'(busy_inc) - BW'(busy_dec);
      end
   end

`ifdef HTU_REF_CNT_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ref_cnt_err <= 1'b0;
      else if ((do_acc && (acc_cur == MAX)) || (do_rel && (rel_cur == '0)))
         ref_cnt_err <= 1'b1;
   end
`else
   assign ref_cnt_err = 1'b0;
`endif

endmodule
